// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter that shares the single register-file
// write port between NUM_REQ writeback sources. The accepted write is
// registered and reaches the register file one cycle after acceptance.
// Contended cycles are counted in a saturating counter. It also provides
// optional writeback forwarding for two read ports.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   - fwd_rdN returns the registered write data when it targets fwd_rsN
//   undefined - fwd_rdN = fwd_rfN (pass-through); the ports exist in both builds
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   freeze                blocks all grants while high
//   req_valid/req_ready   per-requester handshake (req_ready combinational)
//   req_rd/req_wd         packed per-requester destination / data (slice i)
//   we/rd/wd              registered write port to the register file
//   conflict_cnt          saturating count of cycles with >=2 requests
//   fwd_rs1/2, fwd_rf1/2  read addresses and raw register-file read data
//   fwd_rd1/2             forwarded operands
module regfile_wb_arbiter #(
   parameter int unsigned NUM_REQ          = 3,
   parameter int unsigned ADDRESS_BITWIDTH = 5,
   parameter int unsigned DATA_WIDTH       = 32,
   parameter int unsigned CNT_WIDTH        = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             freeze,
   input  logic [NUM_REQ-1:0]               req_valid,
   output logic [NUM_REQ-1:0]               req_ready,
   input  logic [NUM_REQ*ADDRESS_BITWIDTH-1:0] req_rd,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wd,
   output logic                             we,
   output logic [ADDRESS_BITWIDTH-1:0]      rd,
   output logic [DATA_WIDTH-1:0]            wd,
   output logic [CNT_WIDTH-1:0]             conflict_cnt,
   input  logic [ADDRESS_BITWIDTH-1:0]      fwd_rs1,
   input  logic [ADDRESS_BITWIDTH-1:0]      fwd_rs2,
   input  logic [DATA_WIDTH-1:0]            fwd_rf1,
   input  logic [DATA_WIDTH-1:0]            fwd_rf2,
   output logic [DATA_WIDTH-1:0]            fwd_rd1,
   output logic [DATA_WIDTH-1:0]            fwd_rd2
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]            r_rr_ptr;
   logic                        r_we;
   logic [ADDRESS_BITWIDTH-1:0] r_rd;
   logic [DATA_WIDTH-1:0]       r_wd;
   logic [CNT_WIDTH-1:0]        r_conflict_cnt;

   logic                        w_found;
   logic [PTR_W-1:0]            w_scan_idx;
   logic [PTR_W-1:0]            w_gnt_idx;
   logic [ADDRESS_BITWIDTH-1:0] w_gnt_rd;
   logic [DATA_WIDTH-1:0]       w_gnt_wd;
   logic                        w_contend;

   // (base + off) mod NUM_REQ; both operands are already below NUM_REQ
   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                  input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return PTR_W'(s);
   endfunction

   // Round-robin search starting at r_rr_ptr; first valid requester wins
   always_comb begin
      w_found    = 1'b0;
      w_scan_idx = '0;
      w_gnt_idx  = '0;
      w_gnt_rd   = '0;
      w_gnt_wd   = '0;
      req_ready  = '0;
      if (!freeze) begin
         for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_scan_idx = wrap_idx(r_rr_ptr, k);
            if (!w_found && req_valid[w_scan_idx]) begin
               w_found   = 1'b1;
               w_gnt_idx = w_scan_idx;
            end
         end
      end
      // Payload mux over constant slices of the packed request buses
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (w_found && (w_gnt_idx == PTR_W'(i))) begin
            req_ready[i] = 1'b1;
            w_gnt_rd     = req_rd[i*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
            w_gnt_wd     = req_wd[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Contention ignores freeze: any cycle with two or more requests counts
   assign w_contend = ($countones(req_valid) > 1);

   // Write register, round-robin pointer and contention counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we           <= 1'b0;
         r_rd           <= '0;
         r_wd           <= '0;
         r_rr_ptr       <= '0;
         r_conflict_cnt <= '0;
      end else begin
         r_we <= 1'b0;
         if (w_found) begin
            // Writes to x0 are accepted but never reach the register file
            r_we     <= (w_gnt_rd != '0);
            r_rd     <= w_gnt_rd;
            r_wd     <= w_gnt_wd;
            r_rr_ptr <= wrap_idx(w_gnt_idx, 32'd1);
         end
         if (w_contend && (r_conflict_cnt != '1))
            r_conflict_cnt <= r_conflict_cnt + CNT_WIDTH'(1);
      end
   end

   assign we           = r_we;
   assign rd           = r_rd;
   assign wd           = r_wd;
   assign conflict_cnt = r_conflict_cnt;

`ifdef WB_FORWARD_EN
   // Covers the cycle where the registered write is not yet in the register file
   assign fwd_rd1 = (r_we && (r_rd == fwd_rs1) && (fwd_rs1 != '0)) ? r_wd : fwd_rf1;
   assign fwd_rd2 = (r_we && (r_rd == fwd_rs2) && (fwd_rs2 != '0)) ? r_wd : fwd_rf2;
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{fwd_rs1, fwd_rs2};
   assign fwd_rd1      = fwd_rf1;
   assign fwd_rd2      = fwd_rf2;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized scoreboard bench for regfile_wb_arbiter. The stimulus process
// keeps a behavioural model (pending requests, priority index, contention
// count) and pushes every expected register-file write into a queue; the
// monitor process pops and compares on the falling edge.
module tb_regfile_wb_arbiter;

   localparam int unsigned N  = 3;
   localparam int unsigned AW = 5;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 16;

   logic              clk;
   logic              reset;
   logic              freeze;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*AW-1:0]   req_rd;
   logic [N*DW-1:0]   req_wd;
   logic              we;
   logic [AW-1:0]     rd;
   logic [DW-1:0]     wd;
   logic [CW-1:0]     conflict_cnt;
   logic [AW-1:0]     fwd_rs1, fwd_rs2;
   logic [DW-1:0]     fwd_rf1, fwd_rf2;
   logic [DW-1:0]     fwd_rd1, fwd_rd2;

   regfile_wb_arbiter #(
      .NUM_REQ(N), .ADDRESS_BITWIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset(reset), .freeze(freeze),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_rd(req_rd), .req_wd(req_wd),
      .we(we), .rd(rd), .wd(wd), .conflict_cnt(conflict_cnt),
      .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
      .fwd_rf1(fwd_rf1), .fwd_rf2(fwd_rf2),
      .fwd_rd1(fwd_rd1), .fwd_rd2(fwd_rd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      bit          we;
      logic [AW-1:0] rd;
      logic [DW-1:0] wd;
   } exp_t;

   exp_t          q[$];
   int            total = 0;
   int            bad   = 0;
   int unsigned   cyc   = 0;
   bit            mon_en = 1'b0;

   // model state
   bit            pend_v [N];
   logic [AW-1:0] pend_rd[N];
   logic [DW-1:0] pend_wd[N];
   int            rr = 0;
   int            cnt = 0;
   logic [N-1:0]  exp_ready = '0;
   bit            chk_ready = 1'b0;
   logic [AW-1:0] last_rd = '0;
   logic [DW-1:0] last_wd = '0;

   function automatic void check(string nm, logic [63:0] got, logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at cycle %0d", nm, got, exp, cyc);
      end
   endfunction

   // One clock cycle: apply pending requests, predict, then advance the model
   task automatic drive(input bit rst, input bit frz);
      int g;
      int nv;
      logic [N-1:0]    v;
      logic [N*AW-1:0] rdv;
      logic [N*DW-1:0] wdv;
      g = -1; nv = 0; v = '0; rdv = '0; wdv = '0;
      for (int i = 0; i < N; i++) begin
         v[i] = pend_v[i];
         rdv[i*AW +: AW] = pend_rd[i];
         wdv[i*DW +: DW] = pend_wd[i];
         if (pend_v[i]) nv++;
      end
      if (!frz)
         for (int k = 0; k < N; k++)
            if (g < 0 && pend_v[(rr + k) % N]) g = (rr + k) % N;
      reset = rst; freeze = frz;
      req_valid = v; req_rd = rdv; req_wd = wdv;
      fwd_rs1 = AW'($urandom_range(0, 7));
      fwd_rs2 = AW'($urandom_range(0, 7));
      fwd_rf1 = $urandom;
      fwd_rf2 = $urandom;
      exp_ready = (g >= 0) ? N'(1 << g) : '0;
      chk_ready = !rst;
      if (!rst && g >= 0)
         q.push_back('{cyc, (pend_rd[g] != '0), pend_rd[g], pend_wd[g]});
      @(posedge clk); #1;
      cyc++;
      if (rst) begin
         rr = 0; cnt = 0; q.delete(); last_rd = '0; last_wd = '0;
         for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      end else begin
         if (g >= 0) begin
            rr = (g + 1) % N;
            pend_v[g] = 1'b0;
         end
         if (nv >= 2 && cnt < 65535) cnt++;
      end
   endtask

   task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      pend_v[i] = 1'b1; pend_rd[i] = a; pend_wd[i] = d;
   endtask

   // Monitor: pop the write due this cycle, else expect idle with held rd/wd
   always @(negedge clk) begin
      if (mon_en) begin
         exp_t e;
         bit ew;
         logic [AW-1:0] erd;
         logic [DW-1:0] ewd;
         logic [DW-1:0] ef1, ef2;
         if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            ew = e.we; erd = e.rd; ewd = e.wd;
            last_rd = e.rd; last_wd = e.wd;
         end else begin
            ew = 1'b0; erd = last_rd; ewd = last_wd;
         end
         check("we", 64'(we), 64'(ew));
         check("rd", 64'(rd), 64'(erd));
         check("wd", 64'(wd), 64'(ewd));
         check("conflict_cnt", 64'(conflict_cnt), 64'(cnt));
         if (chk_ready) check("req_ready", 64'(req_ready), 64'(exp_ready));
         ef1 = fwd_rf1; ef2 = fwd_rf2;
`ifdef WB_FORWARD_EN
         if (ew && erd == fwd_rs1 && fwd_rs1 != '0) ef1 = ewd;
         if (ew && erd == fwd_rs2 && fwd_rs2 != '0) ef2 = ewd;
`endif
         check("fwd_rd1", 64'(fwd_rd1), 64'(ef1));
         check("fwd_rd2", 64'(fwd_rd2), 64'(ef2));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; freeze = 1'b0; req_valid = '0; req_rd = '0; req_wd = '0;
      fwd_rs1 = '0; fwd_rs2 = '0; fwd_rf1 = '0; fwd_rf2 = '0;
      for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; pend_rd[i] = '0; pend_wd[i] = '0; end

      drive(1, 0);
      mon_en = 1'b1;
      drive(1, 0);

      // single requester 1, rd=5
      set_req(1, 5'd5, 32'hDEADBEEF);
      drive(0, 0);
      drive(0, 0);
      drive(0, 0);

      // all three requesters continuously for 6 cycles from rr=0
      drive(1, 0);
      for (int c = 0; c < 6; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend_v[i]) set_req(i, AW'($urandom_range(1, 31)), $urandom);
         drive(0, 0);
      end
      check("cnt_after_6_contended", 64'(conflict_cnt), 64'd6);
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      drive(0, 0);

      // write to x0 is consumed with we=0
      set_req(0, 5'd0, 32'h1234);
      drive(0, 0);
      drive(0, 0);

      // freeze with requesters 0 and 2 pending
      drive(1, 0);
      set_req(0, 5'd9, 32'h0000_0A0A);
      set_req(2, 5'd10, 32'h0000_0B0B);
      drive(0, 1);
      drive(0, 1);
      drive(0, 1);
      check("cnt_after_freeze", 64'(conflict_cnt), 64'd3);
      drive(0, 0);
      drive(0, 0);
      drive(0, 0);

      // reset during a transfer cycle, then grant restarts at index 0
      set_req(1, 5'd3, 32'h3333_3333);
      drive(0, 0);
      set_req(2, 5'd4, 32'h4444_4444);
      drive(1, 0);
      check("rd_after_reset", 64'(rd), 64'd0);
      set_req(0, 5'd6, 32'h6666_6666);
      set_req(2, 5'd7, 32'h7777_7777);
      drive(0, 0);
      drive(0, 0);
      drive(0, 0);

      // randomized traffic with occasional freeze and reset
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            if (!pend_v[i] && $urandom_range(0, 1) == 1)
               set_req(i, AW'($urandom_range(0, 7)), $urandom);
         drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) == 0));
      end
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      drive(0, 0);
      drive(0, 0);

      @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
